// File: rtl/seu_ip_pkg.sv
// seu_ip_pkg
// Shared types and constants for the 16-bit SECDED Hamming vector produced by
// hamming16t11d_enc.
//   hamming_status_e : sticky scrub status (CLEAN / CORR / FAIL)
//   CHK_POS          : positions of the four syndrome check bits
//   DATA_POS         : vector position holding data bit i
// Position 0 is the overall parity bit.
package seu_ip_pkg;

  typedef enum logic [1:0] {
    ST_CLEAN = 2'd0,
    ST_CORR  = 2'd1,
    ST_FAIL  = 2'd2
  } hamming_status_e;

  localparam int unsigned N_CHK  = 4;
  localparam int unsigned N_DATA = 11;

  localparam logic [3:0] CHK_POS [N_CHK] = '{4'd1, 4'd2, 4'd4, 4'd8};

  localparam logic [3:0] DATA_POS [N_DATA] = '{
    4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
  };

endpackage

// File: rtl/hamming16t11d_dec.sv
// hamming16t11d_dec
// Purely combinational SECDED decoder for the 16-bit Hamming vector.
// Ports:
//   hv_i     in  16  encoded vector ([0] overall parity, [1,2,4,8] check bits)
//   syn_o    out  4  syndrome = position of a single error (0 = parity bit)
//   single_o out  1  single error (overall parity mismatch)
//   double_o out  1  double error (nonzero syndrome, parity matches)
//   data_o   out 11  data extracted from the corrected vector
module hamming16t11d_dec
  import seu_ip_pkg::*;
(
  input  logic [15:0] hv_i,
  output logic [3:0]  syn_o,
  output logic        single_o,
  output logic        double_o,
  output logic [10:0] data_o
);

  logic [15:0] corr;
  logic        par;

  always_comb begin
    syn_o = '0;
    for (int k = 0; k < int'(N_CHK); k++) begin
      for (int pos = 1; pos < 16; pos++) begin
        if ((4'(pos) & CHK_POS[k]) != 4'd0) syn_o[k] = syn_o[k] ^ hv_i[pos];
      end
    end

    par      = ^hv_i;
    single_o = par;
    double_o = !par && (syn_o != 4'd0);

    // On a single error the syndrome names the flipped bit; syndrome 0 means
    // the overall parity bit itself, which carries no data.
    corr = hv_i;
    if (par) corr[syn_o] = ~corr[syn_o];

    data_o = '0;
    for (int i = 0; i < int'(N_DATA); i++) data_o[i] = corr[DATA_POS[i]];
  end

endmodule

// File: rtl/hamming16t11d_scrub_reg.sv
// hamming16t11d_scrub_reg
// SECDED-protected storage register with scrubbing. The held vector is decoded
// every cycle; single errors are written back corrected, double errors are
// reported but never written back.
// Ports:
//   clk_i, rstn_i        clock, async active-low reset
//   we_i, hv_i[15:0]     load a new encoded vector
//   clr_i                clear sticky status and event counters
//   data_o[10:0]         registered corrected data
//   valid_o              a word has been loaded since reset
//   sec_o / ded_o        registered single-corrected / double-detected pulses
//   status_o[1:0]        sticky status: 0 CLEAN, 1 CORR, 2 FAIL
//   sec_cnt_o, ded_cnt_o saturating event counters (CNT_WIDTH bits)
// Build option: define HAMMING16_CNT_EN to implement the event counters;
// otherwise they read as constant 0.
module hamming16t11d_scrub_reg
  import seu_ip_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 we_i,
  input  logic [15:0]          hv_i,
  input  logic                 clr_i,
  output logic [10:0]          data_o,
  output logic                 valid_o,
  output logic                 sec_o,
  output logic                 ded_o,
  output logic [1:0]           status_o,
  output logic [CNT_WIDTH-1:0] sec_cnt_o,
  output logic [CNT_WIDTH-1:0] ded_cnt_o
);

  logic [15:0]     hv_q, hv_d;
  logic [10:0]     data_q;
  logic            loaded_q, valid_q, sec_q, ded_q;
  hamming_status_e status_q;

  logic [3:0]      syn;
  logic            sgl, dbl;
  logic [10:0]     dec_data;

  hamming16t11d_dec u_dec (
    .hv_i     (hv_q),
    .syn_o    (syn),
    .single_o (sgl),
    .double_o (dbl),
    .data_o   (dec_data)
  );

  always_comb begin
    hv_d = hv_q;
    if (we_i)     hv_d = hv_i;
    else if (sgl) hv_d = hv_q ^ (16'd1 << syn);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      hv_q     <= '0;
      data_q   <= '0;
      loaded_q <= 1'b0;
      valid_q  <= 1'b0;
      sec_q    <= 1'b0;
      ded_q    <= 1'b0;
    end else begin
      hv_q     <= hv_d;
      data_q   <= dec_data;
      loaded_q <= loaded_q | we_i;
      valid_q  <= loaded_q;
      sec_q    <= sgl;
      ded_q    <= dbl;
    end
  end

  // Sticky status: clear first, then apply this cycle's event.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      status_q <= ST_CLEAN;
    end else begin
      if (dbl)                                status_q <= ST_FAIL;
      else if (clr_i)                         status_q <= sgl ? ST_CORR : ST_CLEAN;
      else if (sgl && status_q == ST_CLEAN)   status_q <= ST_CORR;
    end
  end

`ifdef HAMMING16_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] sec_cnt_q, sec_cnt_d;
  logic [CNT_WIDTH-1:0] ded_cnt_q, ded_cnt_d;

  always_comb begin
    sec_cnt_d = clr_i ? '0 : sec_cnt_q;
    ded_cnt_d = clr_i ? '0 : ded_cnt_q;
    if (sgl && sec_cnt_d != CNT_MAX) sec_cnt_d = sec_cnt_d + 1'b1;
    if (dbl && ded_cnt_d != CNT_MAX) ded_cnt_d = ded_cnt_d + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sec_cnt_q <= '0;
      ded_cnt_q <= '0;
    end else begin
      sec_cnt_q <= sec_cnt_d;
      ded_cnt_q <= ded_cnt_d;
    end
  end

  assign sec_cnt_o = sec_cnt_q;
  assign ded_cnt_o = ded_cnt_q;
`else
  assign sec_cnt_o = '0;
  assign ded_cnt_o = '0;
`endif

  assign data_o   = data_q;
  assign valid_o  = valid_q;
  assign sec_o    = sec_q;
  assign ded_o    = ded_q;
  assign status_o = status_q;

endmodule

// File: tb/tb_hamming16t11d_scrub_reg.sv
// tb_hamming16t11d_scrub_reg
// Directed bench for hamming16t11d_scrub_reg. A second instance with
// CNT_WIDTH=2 shares the stimulus and is used for the saturation case.
// Counter expectations follow HAMMING16_CNT_EN (0 when the macro is undefined).
module tb_hamming16t11d_scrub_reg;

`ifdef HAMMING16_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        we_i = 1'b0;
  logic [15:0] hv_i = '0;
  logic        clr_i = 1'b0;

  logic [10:0] data_o, data2_o;
  logic        valid_o, valid2_o, sec_o, sec2_o, ded_o, ded2_o;
  logic [1:0]  status_o, status2_o;
  logic [7:0]  sec_cnt_o, ded_cnt_o;
  logic [1:0]  sec_cnt2_o, ded_cnt2_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  hamming16t11d_scrub_reg #(.CNT_WIDTH(8)) u_dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .we_i(we_i), .hv_i(hv_i), .clr_i(clr_i),
    .data_o(data_o), .valid_o(valid_o), .sec_o(sec_o), .ded_o(ded_o),
    .status_o(status_o), .sec_cnt_o(sec_cnt_o), .ded_cnt_o(ded_cnt_o)
  );

  hamming16t11d_scrub_reg #(.CNT_WIDTH(2)) u_dut2 (
    .clk_i(clk_i), .rstn_i(rstn_i), .we_i(we_i), .hv_i(hv_i), .clr_i(clr_i),
    .data_o(data2_o), .valid_o(valid2_o), .sec_o(sec2_o), .ded_o(ded2_o),
    .status_o(status2_o), .sec_cnt_o(sec_cnt2_o), .ded_cnt_o(ded_cnt2_o)
  );

  typedef struct {
    logic [15:0] hv;
    logic [10:0] data;
    logic        sec;
    logic        ded;
    logic [15:0] hv_after;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cexp(input int v);
    return CNT_EN ? 32'(v) : 32'd0;
  endfunction

  // Drive a write in cycle c; returns at the negedge after E(c+1).
  task automatic write_hv(input logic [15:0] v);
    @(negedge clk_i);
    we_i = 1'b1;
    hv_i = v;
    @(negedge clk_i);
    we_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic clear_pulse();
    @(negedge clk_i);
    clr_i = 1'b1;
    @(negedge clk_i);
    clr_i = 1'b0;
  endtask

  initial begin
    vecs[0] = '{16'hFFFF, 11'h7FF, 1'b0, 1'b0, 16'hFFFF};
    vecs[1] = '{16'h000F, 11'h001, 1'b0, 1'b0, 16'h000F};
    vecs[2] = '{16'h8117, 11'h400, 1'b0, 1'b0, 16'h8117};
    vecs[3] = '{16'h8517, 11'h400, 1'b1, 1'b0, 16'h8117};
    vecs[4] = '{16'h000B, 11'h001, 1'b1, 1'b0, 16'h000F};
    vecs[5] = '{16'h0080, 11'h000, 1'b1, 1'b0, 16'h0000};
    vecs[6] = '{16'h0001, 11'h000, 1'b1, 1'b0, 16'h0000};
    vecs[7] = '{16'h003F, 11'h003, 1'b0, 1'b1, 16'h003F};
    vecs[8] = '{16'h0003, 11'h000, 1'b0, 1'b1, 16'h0003};
    vecs[9] = '{16'hFFFF, 11'h7FF, 1'b0, 1'b0, 16'hFFFF};

    // Reset values
    #3;
    chk("rst_data", 32'(data_o), 0);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_sec", 32'(sec_o), 0);
    chk("rst_ded", 32'(ded_o), 0);
    chk("rst_status", 32'(status_o), 0);
    chk("rst_sec_cnt", 32'(sec_cnt_o), 0);
    chk("rst_ded_cnt", 32'(ded_cnt_o), 0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    chk("idle_valid", 32'(valid_o), 0);
    chk("idle_sec", 32'(sec_o), 0);

    // Table: one write each, check after E(c+1) and one cycle later
    for (int i = 0; i < 10; i++) begin
      write_hv(vecs[i].hv);
      chk($sformatf("v%0d_data", i), 32'(data_o), 32'(vecs[i].data));
      chk($sformatf("v%0d_valid", i), 32'(valid_o), 1);
      chk($sformatf("v%0d_sec", i), 32'(sec_o), 32'(vecs[i].sec));
      chk($sformatf("v%0d_ded", i), 32'(ded_o), 32'(vecs[i].ded));
      chk($sformatf("v%0d_hv_q", i), 32'(u_dut.hv_q), 32'(vecs[i].hv_after));
      @(negedge clk_i);
      chk($sformatf("v%0d_sec_next", i), 32'(sec_o), 0);
      chk($sformatf("v%0d_ded_next", i), 32'(ded_o), 32'(vecs[i].ded));
      chk($sformatf("v%0d_data_next", i), 32'(data_o), 32'(vecs[i].data));
    end

    clear_pulse();
    chk("clr_status", 32'(status_o), 0);
    chk("clr_sec_cnt", 32'(sec_cnt_o), 0);
    chk("clr_ded_cnt", 32'(ded_cnt_o), 0);

    // Single error on data bit 7, scrubbed
    write_hv(16'h0080);
    chk("s80_sec", 32'(sec_o), 1);
    chk("s80_data", 32'(data_o), 0);
    chk("s80_hv_q", 32'(u_dut.hv_q), 0);
    chk("s80_sec_cnt", 32'(sec_cnt_o), cexp(1));
    chk("s80_status", 32'(status_o), 1);
    @(negedge clk_i);
    chk("s80_sec_pulse_end", 32'(sec_o), 0);
    chk("s80_sec_cnt_hold", 32'(sec_cnt_o), cexp(1));
    chk("s80_status_hold", 32'(status_o), 1);

    // Overall parity bit flipped
    write_hv(16'h0001);
    chk("s01_sec", 32'(sec_o), 1);
    chk("s01_data", 32'(data_o), 0);
    chk("s01_hv_q", 32'(u_dut.hv_q), 0);
    chk("s01_sec_cnt", 32'(sec_cnt_o), cexp(2));

    // Persistent double error: ded counts once per held cycle
    write_hv(16'h0003);
    chk("d03_ded_1", 32'(ded_o), 1);
    chk("d03_ded_cnt_1", 32'(ded_cnt_o), cexp(1));
    repeat (3) @(negedge clk_i);
    chk("d03_ded_4", 32'(ded_o), 1);
    chk("d03_ded_cnt_4", 32'(ded_cnt_o), cexp(4));
    chk("d03_status", 32'(status_o), 2);
    chk("d03_hv_q", 32'(u_dut.hv_q), 16'h0003);
    chk("d03_sec", 32'(sec_o), 0);
    clear_pulse();
    chk("d03_clr_status", 32'(status_o), 2);
    chk("d03_clr_ded_cnt", 32'(ded_cnt_o), cexp(1));
    chk("d03_clr_sec_cnt", 32'(sec_cnt_o), 0);

    // Saturation: 5 scrubbed singles on the 2-bit counter instance
    write_hv(16'h0000);
    clear_pulse();
    chk("sat_pre_status", 32'(status_o), 0);
    chk("sat_pre_status2", 32'(status2_o), 0);
    chk("sat_pre_cnt2", 32'(sec_cnt2_o), 0);
    for (int i = 0; i < 5; i++) begin
      write_hv(16'h0080);
      @(negedge clk_i);
    end
    chk("sat_cnt2", 32'(sec_cnt2_o), cexp(3));
    chk("sat_cnt8", 32'(sec_cnt_o), cexp(5));
    chk("sat_status2", 32'(status2_o), 1);
    clear_pulse();
    chk("sat_clr_cnt2", 32'(sec_cnt2_o), 0);
    chk("sat_clr_status2", 32'(status2_o), 0);
    chk("sat_clr_status", 32'(status_o), 0);

    // Async reset while an uncorrected single error is held
    @(negedge clk_i);
    we_i = 1'b1;
    hv_i = 16'h0080;
    @(negedge clk_i);
    we_i = 1'b0;
    chk("ar_hv_loaded", 32'(u_dut.hv_q), 16'h0080);
    rstn_i = 1'b0;
    #1;
    chk("ar_hv_q", 32'(u_dut.hv_q), 0);
    chk("ar_data", 32'(data_o), 0);
    chk("ar_valid", 32'(valid_o), 0);
    chk("ar_sec", 32'(sec_o), 0);
    chk("ar_ded", 32'(ded_o), 0);
    chk("ar_status", 32'(status_o), 0);
    chk("ar_sec_cnt", 32'(sec_cnt_o), 0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("ar_post_valid", 32'(valid_o), 0);
    chk("ar_post_sec", 32'(sec_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hamming16t11d_scrub_reg.md
# hamming16t11d_scrub_reg

SECDED-protected storage register that consumes the 16-bit Hamming vector produced by `hamming16t11d_enc`. It holds the codeword and decodes it every cycle, correcting single-bit upsets and detecting double-bit upsets. Single-bit upsets are scrubbed back into storage; detected events are reported through pulses, a sticky status state machine and saturating event counters. The block sits in the SEU-hardening path, between the encoder and any logic that consumes protected configuration or state.

## Interface
- `CNT_WIDTH`, 8, width of each saturating event counter (range 1..16).
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rstn_i`  in  1  asynchronous reset, active-low.
- `we_i`  in  1  load `hv_i` into storage at the next edge.
- `hv_i`  in  16  encoded vector from the encoder: [0] overall parity; [1],[2],[4],[8] check bits; the remaining positions carry data.
- `clr_i`  in  1  clear the sticky status and both counters.
- `data_o`  out  11  decoded and corrected data, registered.
- `valid_o`  out  1  `data_o` reflects a loaded word.
- `sec_o`  out  1  registered pulse: single error corrected.
- `ded_o`  out  1  registered pulse: double error detected.
- `status_o`  out  2  sticky state: 0 CLEAN, 1 CORR, 2 FAIL.
- `sec_cnt_o`  out  CNT_WIDTH  number of corrected events.
- `ded_cnt_o`  out  CNT_WIDTH  number of uncorrectable events.

## Operation
- Storage `hv_q[15:0]` resets to 0. The all-zero word is a valid codeword.
- Combinational decode of `hv_q`:
  - Syndrome `s[k]` = XOR of every position whose index has bit k set, over positions 1..15, k=0..3.
  - Parity `p` = XOR of `hv_q[15:0]`.
- Decode classification:
  - s=0, p=0: clean.
  - p=1: single error at position s. Position 0 is the overall-parity bit. Flip that bit to form `hv_corr`.
  - s≠0, p=0: double error. `hv_corr` = `hv_q` unchanged.
- Data extraction from `hv_corr`: positions 3,5,6,7,9,10,11,12,13,14,15 map to data[0..10].
- Storage update priority at each edge:
  1. `we_i`: `hv_q` ← `hv_i`.
  2. Single error and no `we_i`: `hv_q` ← `hv_corr` (scrub).
  3. Otherwise hold.
  - A double error is never written back.
- Output register at each edge:
  - `data_o` ← extracted data; `sec_o` ← single; `ded_o` ← double.
  - These outputs always describe the word held during the cycle just ended, even when `we_i` replaces it at the same edge.
- `loaded_q` sets on the first `we_i` and is cleared only by reset. `valid_o` ← `loaded_q`.
- Status FSM, evaluated per edge:
  - First, `clr_i` forces CLEAN.
  - Then the current-cycle event is applied: single moves CLEAN→CORR; double moves any state→FAIL.
  - FAIL leaves only through `clr_i`, with no double error in the same cycle.
  - CORR never returns to CLEAN without `clr_i`.
- Counters: `clr_i` zeroes them first, then the current event increments. Simultaneous clear and event yields 1. Counters saturate at 2^CNT_WIDTH−1 and never wrap.

## Timing
- Reset values: `data_o`=0, `valid_o`=0, `sec_o`=0, `ded_o`=0, `status_o`=CLEAN, both counters 0.
- Write latency:
  - `we_i` high in cycle c loads `hv_q` at edge E(c).
  - `data_o`, `sec_o`/`ded_o` and the counters reflect that word after edge E(c+1).
  - `valid_o` rises after E(c+1).
- A scrubbed single error produces a 1-cycle `sec_o` pulse, because the next cycle decodes clean.
- A persistent double error asserts `ded_o` every cycle and increments `ded_cnt_o` every cycle until the word is overwritten.
- Asynchronous reset mid-operation returns every register to its reset value immediately; no partial scrub survives.

## Configuration
- `HAMMING16_CNT_EN` defined: both counters are implemented as specified.
- `HAMMING16_CNT_EN` undefined: no counter flops are implemented, and `sec_cnt_o`/`ded_cnt_o` are tied to 0.
- The ports exist in both builds. The status FSM and pulses are unaffected.

## Structure
- `seu_ip_pkg` holds:
  - the status enum `hamming_status_e` (CLEAN/CORR/FAIL, 2 bits);
  - the check-bit position constants (1,2,4,8);
  - the data-position map array.
- One combinational sub-module, `hamming16t11d_dec`: 16-bit vector in; syndrome, single, double and corrected 11-bit data out. It is reusable by other consumers of the encoder.

## Test plan
- Write `hv_i`=16'hFFFF (data 11'h7FF) → after E(c+1): `data_o`=11'h7FF, `valid_o`=1, `sec_o`=0, `ded_o`=0, `status_o`=CLEAN.
- Write 16'h0080 (data 0, bit 7 flipped) → `sec_o` pulses for exactly 1 cycle, `data_o`=0, `hv_q` scrubbed to 16'h0000, `sec_cnt_o`=1, `status_o`=CORR.
- Write 16'h0001 (overall-parity bit flipped) → `sec_o`=1, `data_o`=0, `hv_q` returns to 0.
- Write 16'h0003 (double error) → `ded_o` stays high for 4 held cycles, `ded_cnt_o`=4, `status_o`=FAIL, `hv_q` still 16'h0003. Then `clr_i` together with a further double error → `status_o`=FAIL, `ded_cnt_o`=1.
- With `CNT_WIDTH`=2, apply 5 scrubbed single errors → `sec_cnt_o` holds 3. Then `clr_i` alone → counter 0, `status_o`=CLEAN.
- Assert `rstn_i`=0 while 16'h0080 is held → all outputs 0 / CLEAN immediately. Build without `HAMMING16_CNT_EN` → both counters read 0 in all scenarios above.
